// File: rtl/neuron_mac.sv
// rtl/neuron_mac.sv - single-neuron multiply-accumulate with bias preload and output saturation
//
// Purpose: computes sat(bias + sum_k pixel[k] * weight[k]) over N_INPUTS pixels.
// Pixels arrive on a valid/ready stream; weights come from a synchronous ROM
// (1-cycle read latency) addressed by w_addr.
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   start, bias          begin a neuron (honoured only when idle); bias sampled then
//   in_valid/in_ready    pixel stream handshake, in_data unsigned pixel
//   w_addr, w_data       weight ROM address out, signed weight back one cycle later
//   busy                 high from accepted start through the sum_valid cycle
//   sum, sum_valid       saturated signed result and its 1-cycle update strobe
module neuron_mac #(
  parameter int N_INPUTS = 784,
  parameter int PIX_W    = 8,
  parameter int WGT_W    = 8,
  parameter int OUT_W    = 22,
  parameter int ACC_W    = 28,
  parameter int ADDR_W   = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic signed [OUT_W-1:0]  bias,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PIX_W-1:0]         in_data,
  output logic [ADDR_W-1:0]        w_addr,
  input  logic signed [WGT_W-1:0]  w_data,
  output logic                     busy,
  output logic signed [OUT_W-1:0]  sum,
  output logic                     sum_valid
);

  localparam int PROD_W = PIX_W + WGT_W + 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_INPUTS - 1);

  typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_t;

  state_t                    state, state_next;
  logic [ADDR_W-1:0]         counter;
  logic [PIX_W-1:0]          pix_q;
  logic                      pv_q;
  logic signed [ACC_W-1:0]   acc;
  logic                      transfer;
  logic signed [PIX_W:0]     pix_s;
  logic signed [PROD_W-1:0]  prod;
  logic [ACC_W-OUT_W:0]      acc_top;
  logic                      acc_fits;
  logic signed [OUT_W-1:0]   acc_sat;

  assign w_addr   = counter;
  assign transfer = in_valid && in_ready;

  // Pixel is unsigned: a zero sign bit makes it a non-negative signed operand.
  assign pix_s = $signed({1'b0, pix_q});
  assign prod  = PROD_W'(pix_s) * PROD_W'(w_data);

  // The value fits in OUT_W when every bit above the output sign bit equals it.
  assign acc_top  = acc[ACC_W-1:OUT_W-1];
  assign acc_fits = (&acc_top) || !(|acc_top);
  assign acc_sat  = acc_fits ? acc[OUT_W-1:0]
                  : (acc[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                  : {1'b0, {(OUT_W-1){1'b1}}});

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = ACC;
      end
      ACC: begin
        in_ready = 1'b1;
        if (in_valid && (counter == LAST_IDX)) state_next = DRAIN;
      end
      DRAIN: begin
        // While pv_q is set the last product is still being added.
        if (!pv_q) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter   <= '0;
      pix_q     <= '0;
      pv_q      <= 1'b0;
      acc       <= '0;
      busy      <= 1'b0;
      sum       <= '0;
      sum_valid <= 1'b0;
    end else begin
      pv_q      <= transfer;
      sum_valid <= 1'b0;
      if (transfer) begin
        pix_q   <= in_data;
        counter <= counter + 1'b1;
      end
      if (state == IDLE && start) begin
        acc     <= ACC_W'(bias);
        counter <= '0;
        busy    <= 1'b1;
      end else if (pv_q) begin
        // w_data now belongs to the address that was presented with pix_q.
        acc <= acc + ACC_W'(prod);
      end
      if (state == DRAIN && !pv_q) begin
        sum       <= acc_sat;
        sum_valid <= 1'b1;
      end
      if (state == DONE) busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_neuron_mac.sv
// tb/tb_neuron_mac.sv - self-checking bench for neuron_mac
module tb_neuron_mac;

  typedef struct {
    int bias;
    int pix[4];
    int wgt[4];
    int gap;   // 0 continuous, 1 alternate gaps, 2 random gaps
    int spur;  // 1: pulse start during ACC and during DONE
    int exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic               start4 = 1'b0;
  logic signed [21:0] bias4 = '0;
  logic               in_valid4 = 1'b0;
  logic               in_ready4;
  logic [7:0]         in_data4 = '0;
  logic [9:0]         w_addr4;
  logic signed [7:0]  w_data4 = '0;
  logic               busy4;
  logic signed [21:0] sum4;
  logic               sum_valid4;
  logic signed [7:0]  rom4 [4];

  logic               start_b = 1'b0;
  logic signed [21:0] bias_b = '0;
  logic               in_valid_b = 1'b0;
  logic               in_ready_b;
  logic [7:0]         in_data_b = '0;
  logic [9:0]         w_addr_b;
  logic signed [7:0]  w_data_b = '0;
  logic               busy_b;
  logic signed [21:0] sum_b;
  logic               sum_valid_b;
  logic signed [7:0]  big_w = '0;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  neuron_mac #(.N_INPUTS(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .bias(bias4),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
    .w_addr(w_addr4), .w_data(w_data4), .busy(busy4),
    .sum(sum4), .sum_valid(sum_valid4)
  );

  neuron_mac dut_big (
    .clk(clk), .rst(rst), .start(start_b), .bias(bias_b),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
    .w_addr(w_addr_b), .w_data(w_data_b), .busy(busy_b),
    .sum(sum_b), .sum_valid(sum_valid_b)
  );

  // Synchronous weight ROMs, 1-cycle read latency.
  always @(posedge clk) begin
    w_data4  <= (w_addr4 < 10'd4) ? rom4[w_addr4[1:0]] : 8'sd0;
    w_data_b <= big_w;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input int b, input int p0, input int p1, input int p2, input int p3,
                              input int w0, input int w1, input int w2, input int w3,
                              input int gap, input int spur, input int exp);
    vec_t v;
    v.bias = b;
    v.pix[0] = p0; v.pix[1] = p1; v.pix[2] = p2; v.pix[3] = p3;
    v.wgt[0] = w0; v.wgt[1] = w1; v.wgt[2] = w2; v.wgt[3] = w3;
    v.gap = gap; v.spur = spur; v.exp = exp;
    return v;
  endfunction

  // Reference: plain integer dot product plus bias, clamped to 22-bit signed.
  function automatic int model(input vec_t v);
    longint s;
    s = v.bias;
    for (int i = 0; i < 4; i++) s += longint'(v.pix[i]) * longint'(v.wgt[i]);
    if (s > 2097151) s = 2097151;
    if (s < -2097152) s = -2097152;
    return int'(s);
  endfunction

  task automatic run4(input vec_t v, input string tag);
    int k, cyc, lat, pulses, got;
    bit vld, take, addr_ok;
    for (int i = 0; i < 4; i++) rom4[i] = 8'(v.wgt[i]);
    bias4 = 22'(v.bias);
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    chk({tag, "_busy_start"}, busy4, 1);
    k = 0; cyc = 0; addr_ok = 1'b1;
    while (k < 4 && cyc < 100) begin
      case (v.gap)
        0: vld = 1'b1;
        1: vld = (cyc % 2 == 0);
        default: vld = 1'($urandom_range(0, 1));
      endcase
      in_valid4 = vld;
      in_data4 = vld ? 8'(v.pix[k]) : 8'($urandom);
      start4 = (v.spur != 0) && (cyc == 2);
      if (w_addr4 != 10'(k)) addr_ok = 1'b0;
      take = vld && in_ready4;
      step();
      if (take) k++;
      cyc++;
    end
    start4 = 1'b0;
    chk({tag, "_transfers"}, k, 4);
    chk({tag, "_waddr_track"}, addr_ok, 1);
    chk({tag, "_ready_drop"}, in_ready4, 0);
    // Keep in_valid high afterwards: must be ignored outside ACC.
    in_valid4 = 1'b1;
    in_data4 = 8'hFF;
    pulses = 0; lat = 0; got = 0;
    for (int j = 1; j <= 6; j++) begin
      start4 = (v.spur != 0) && (lat != 0) && (lat == j - 1);
      step();
      if (sum_valid4) begin
        pulses++;
        if (lat == 0) begin
          lat = j;
          got = int'(sum4);
        end
      end
    end
    start4 = 1'b0;
    in_valid4 = 1'b0;
    chk({tag, "_sum"}, got, v.exp);
    chk({tag, "_pulses"}, pulses, 1);
    chk({tag, "_latency"}, lat, 2);
    chk({tag, "_busy_end"}, busy4, 0);
    chk({tag, "_sum_hold"}, int'(sum4), v.exp);
    chk({tag, "_waddr_end"}, w_addr4, 4);
  endtask

  task automatic run_big(input int wv, input int exp, input string tag);
    int k, cyc, got, pulses;
    big_w = 8'(wv);
    bias_b = '0;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    in_valid_b = 1'b1;
    in_data_b = 8'd255;
    k = 0; cyc = 0;
    while (k < 784 && cyc < 2000) begin
      bit take;
      take = in_ready_b;
      step();
      if (take) k++;
      cyc++;
    end
    in_valid_b = 1'b0;
    chk({tag, "_transfers"}, k, 784);
    got = 0; pulses = 0;
    for (int j = 0; j < 6; j++) begin
      step();
      if (sum_valid_b) begin
        pulses++;
        got = int'(sum_b);
      end
    end
    chk({tag, "_sum"}, got, exp);
    chk({tag, "_pulses"}, pulses, 1);
  endtask

  vec_t tbl[9];
  vec_t rv;

  initial begin
    tbl[0] = mk(0,        1, 2, 3, 4,      1, 1, 1, 1,       0, 0, 10);
    tbl[1] = mk(-16640,   0, 0, 0, 0,      5, -7, 100, -128, 0, 0, -16640);
    tbl[2] = mk(0,        10, 20, 30, 40,  2, -1, 3, 0,      1, 0, 90);
    tbl[3] = mk(0,        10, 20, 30, 40,  2, -1, 3, 0,      0, 0, 90);
    tbl[4] = mk(2097151,  255, 255, 255, 255, 127, 127, 127, 127, 0, 0, 2097151);
    tbl[5] = mk(-2097152, 255, 255, 255, 255, -128, -128, -128, -128, 0, 0, -2097152);
    tbl[6] = mk(2097100,  51, 0, 0, 0,     1, 0, 0, 0,       0, 0, 2097151);
    tbl[7] = mk(-2097100, 53, 0, 0, 0,     -1, 0, 0, 0,      1, 0, -2097152);
    tbl[8] = mk(0,        1, 2, 3, 4,      1, 1, 1, 1,       0, 1, 10);

    rom4[0] = 0; rom4[1] = 0; rom4[2] = 0; rom4[3] = 0;
    step();
    step();
    chk("rst_in_ready", in_ready4, 0);
    chk("rst_busy", busy4, 0);
    chk("rst_sum", int'(sum4), 0);
    chk("rst_sum_valid", sum_valid4, 0);
    chk("rst_w_addr", w_addr4, 0);
    rst = 1'b0;
    step();

    for (int t = 0; t < 9; t++) run4(tbl[t], $sformatf("vec%0d", t));

    // Abort mid-neuron with an asynchronous reset after two transfers.
    for (int i = 0; i < 4; i++) rom4[i] = 8'sd3;
    bias4 = 22'sd5;
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    in_valid4 = 1'b1;
    in_data4 = 8'd7;
    step();
    step();
    chk("abort_pre_waddr", w_addr4, 2);
    rst = 1'b1;
    #1;
    chk("abort_in_ready", in_ready4, 0);
    chk("abort_busy", busy4, 0);
    chk("abort_sum", int'(sum4), 0);
    chk("abort_w_addr", w_addr4, 0);
    step();
    rst = 1'b0;
    in_valid4 = 1'b0;
    begin
      int sv_seen;
      sv_seen = 0;
      for (int j = 0; j < 8; j++) begin
        step();
        if (sum_valid4) sv_seen++;
      end
      chk("abort_no_sum_valid", sv_seen, 0);
      chk("abort_idle_busy", busy4, 0);
    end
    run4(tbl[0], "rerun");

    for (int r = 0; r < 16; r++) begin
      rv.bias = (r % 2 == 0) ? int'($signed(22'($urandom)))
              : ((r % 4 == 1) ? 2097151 - int'($urandom_range(0, 150000))
                              : -2097152 + int'($urandom_range(0, 150000)));
      for (int i = 0; i < 4; i++) begin
        rv.pix[i] = int'($urandom_range(0, 255));
        rv.wgt[i] = int'($urandom_range(0, 255)) - 128;
      end
      rv.gap = 2;
      rv.spur = int'($urandom_range(0, 1));
      rv.exp = model(rv);
      run4(rv, $sformatf("rnd%0d", r));
    end

    run_big(127, 2097151, "big_pos");
    run_big(-128, -2097152, "big_neg");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
